// File: rtl/branch_pkg.sv
// Shared types for the branch predictor / resolve pair: FSM states, queue entry
// layout and the predictor's 2-bit saturating counter encodings.
package branch_pkg;

  localparam int BR_PC_W = 32;

  typedef enum logic {
    RUN,
    RECOVER
  } br_state_t;

  typedef struct packed {
    logic               pred_taken;
    logic [BR_PC_W-1:0] alt_pc;
  } br_entry_t;

  typedef enum logic [1:0] {
    PRED_SNT = 2'b00,
    PRED_WNT = 2'b01,
    PRED_WT  = 2'b10,
    PRED_ST  = 2'b11
  } pred_ctr_t;

endpackage

// File: rtl/branch_pred_fifo.sv
// In-order prediction queue; clear wins over a same-cycle push or pop.
module branch_pred_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 33,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-side branch resolution: compares outcome to the queued prediction,
// strobes predictor updates, and flushes/stalls fetch on a mispredict.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int PC_W    = BR_PC_W,
  parameter int CNT_W   = 16,
  parameter int PENALTY = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic             push_pred_taken,
  input  logic [PC_W-1:0]  push_alt_pc,
  input  logic             res_valid,
  input  logic             res_taken,
  output logic             upd_valid,
  output logic             upd_taken,
  output logic             flush,
  output logic [PC_W-1:0]  redirect_pc,
  output logic             busy,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count,
  output logic             err_underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(PENALTY + 1);

  br_state_t     state_q, state_d;
  logic [PW-1:0] pen_q, pen_d;
  br_entry_t     wr_entry, head;
  logic          q_full, q_empty;
  logic [AW:0]   q_count;
  logic          run, push_acc, res_acc, mispred, underflow;

  assign run        = (state_q == RUN);
  assign push_ready = !q_full && run;
  assign push_acc   = push_valid && push_ready;
  assign res_acc    = run && res_valid && !q_empty;
  assign mispred    = res_acc && (res_taken != head.pred_taken);
  // Keyed off the raw count so a resolve against an empty queue is flagged
  // even though it never reaches the compare path.
  assign underflow  = run && res_valid && (q_count == '0);
  assign busy       = !run;

  always_comb begin
    wr_entry            = '0;
    wr_entry.pred_taken = push_pred_taken;
    wr_entry.alt_pc     = BR_PC_W'(push_alt_pc);
  end

  branch_pred_fifo #(.DEPTH(DEPTH), .W($bits(br_entry_t))) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_acc),
    .pop   (res_acc),
    .clear (mispred),
    .wdata (wr_entry),
    .rdata (head),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      pen_q   <= '0;
    end else begin
      state_q <= state_d;
      pen_q   <= pen_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pen_d   = pen_q;
    case (state_q)
      RUN: if (mispred) begin
        state_d = RECOVER;
        pen_d   = PW'(PENALTY);
      end
      RECOVER: begin
        pen_d = pen_q - 1'b1;
        if (pen_q == PW'(1)) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      upd_valid        <= 1'b0;
      upd_taken        <= 1'b0;
      flush            <= 1'b0;
      redirect_pc      <= '0;
      branch_count     <= '0;
      mispredict_count <= '0;
      err_underflow    <= 1'b0;
    end else begin
      upd_valid <= res_acc;
      upd_taken <= res_acc && res_taken;
      flush     <= mispred;
      if (mispred) redirect_pc <= head.alt_pc[PC_W-1:0];
      if (res_acc && (branch_count != '1)) branch_count <= branch_count + 1'b1;
      if (mispred && (mispredict_count != '1)) mispredict_count <= mispredict_count + 1'b1;
      if (underflow) err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Drives directed and random fetch/resolve traffic and compares every cycle
// against a queue-based reference model of the resolve unit.
module tb_branch_resolve_unit;

  localparam int DEPTH   = 4;
  localparam int PC_W    = 32;
  localparam int CNT_W   = 2;
  localparam int PENALTY = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             push_valid = 1'b0, push_pred_taken = 1'b0;
  logic [PC_W-1:0]  push_alt_pc = '0;
  logic             res_valid = 1'b0, res_taken = 1'b0;
  logic             push_ready, upd_valid, upd_taken, flush, busy, err_underflow;
  logic [PC_W-1:0]  redirect_pc;
  logic [CNT_W-1:0] branch_count, mispredict_count;

  branch_resolve_unit #(.DEPTH(DEPTH), .PC_W(PC_W), .CNT_W(CNT_W), .PENALTY(PENALTY)) dut (
    .clk(clk), .reset(reset),
    .push_valid(push_valid), .push_ready(push_ready),
    .push_pred_taken(push_pred_taken), .push_alt_pc(push_alt_pc),
    .res_valid(res_valid), .res_taken(res_taken),
    .upd_valid(upd_valid), .upd_taken(upd_taken),
    .flush(flush), .redirect_pc(redirect_pc), .busy(busy),
    .branch_count(branch_count), .mispredict_count(mispredict_count),
    .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          t;
    logic [31:0] a;
  } ent_t;

  ent_t        mq[$];
  int          m_rec;
  int          m_bc, m_mc;
  bit          m_err, m_uv, m_ut, m_fl;
  logic [31:0] m_redir;
  int          checks = 0, errors = 0;
  int          max_cnt = (1 << CNT_W) - 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_rec = 0; m_bc = 0; m_mc = 0;
    m_err = 0; m_uv = 0; m_ut = 0; m_fl = 0; m_redir = '0;
  endtask

  task automatic check_regs();
    chk("upd_valid", upd_valid, m_uv);
    chk("upd_taken", upd_taken, m_ut);
    chk("flush", flush, m_fl);
    chk("redirect_pc", redirect_pc, m_redir);
    chk("branch_count", branch_count, m_bc);
    chk("mispredict_count", mispredict_count, m_mc);
    chk("err_underflow", err_underflow, m_err);
  endtask

  // One clock: apply inputs, check combinational outputs, advance model, check registered outputs.
  task automatic cyc(input bit pv, input bit pt, input logic [31:0] pc, input bit rv, input bit rt);
    bit   pr;
    ent_t h;
    push_valid = pv; push_pred_taken = pt; push_alt_pc = pc;
    res_valid = rv; res_taken = rt;
    #1;
    pr = (mq.size() < DEPTH) && (m_rec == 0);
    chk("push_ready", push_ready, pr);
    chk("busy", busy, m_rec > 0);
    m_uv = 0; m_ut = 0; m_fl = 0;
    if (m_rec > 0) begin
      m_rec--;
    end else if (rv && mq.size() == 0) begin
      m_err = 1;
      if (pv && pr) mq.push_back('{t: pt, a: pc});
    end else if (rv) begin
      h = mq.pop_front();
      m_uv = 1; m_ut = rt;
      if (m_bc < max_cnt) m_bc++;
      if (rt != h.t) begin
        if (m_mc < max_cnt) m_mc++;
        m_fl = 1; m_redir = h.a;
        mq.delete();
        m_rec = PENALTY;
      end else if (pv && pr) begin
        mq.push_back('{t: pt, a: pc});
      end
    end else if (pv && pr) begin
      mq.push_back('{t: pt, a: pc});
    end
    @(posedge clk); #1;
    check_regs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    #2;
    chk("rst_push_ready", push_ready, 1);
    chk("rst_busy", busy, 0);
    check_regs();
    @(posedge clk); #1;
    reset = 1'b0;

    // Three correct predictions
    cyc(1, 1, 32'h100, 0, 0);
    cyc(1, 0, 32'h200, 0, 0);
    cyc(1, 1, 32'h300, 0, 0);
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 1);
    chk("dir_bc3", branch_count, 3);
    chk("dir_mc0", mispredict_count, 0);
    idle(1);

    // Mispredict: NT predicted, T resolved, younger entry squashed
    cyc(1, 0, 32'h400, 0, 0);
    cyc(1, 1, 32'h500, 0, 0);
    cyc(0, 0, 0, 1, 1);
    chk("dir_flush", flush, 1);
    chk("dir_redirect", redirect_pc, 32'h400);
    idle(4);
    cyc(0, 0, 0, 1, 0);          // queue was squashed -> underflow
    chk("dir_uflow", err_underflow, 1);

    // Full queue: resolve + push same cycle, push refused
    for (int i = 0; i < DEPTH; i++) cyc(1, 1, 32'h600 + i, 0, 0);
    chk("dir_full_ready", push_ready, 0);
    cyc(1, 0, 32'h700, 1, 1);
    cyc(1, 0, 32'h800, 0, 0);
    chk("dir_refill_ready", push_ready, 0);

    // Mispredict with push, then resolve during RECOVER
    cyc(1, 1, 32'h900, 1, 0);
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 1, 1);
    idle(2);

    // Mispredict then reset mid-recovery
    cyc(1, 0, 32'hA00, 0, 0);
    cyc(0, 0, 0, 1, 1);
    chk("pre_rst_busy", busy, 1);
    reset = 1'b1;
    #1;
    model_reset();
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", push_ready, 1);
    check_regs();
    @(posedge clk); #1;
    reset = 1'b0;

    // Five mispredicts saturate the 2-bit count
    for (int i = 0; i < 5; i++) begin
      cyc(1, 1, 32'hB00 + i, 0, 0);
      cyc(0, 0, 0, 1, 0);
      idle(PENALTY);
    end
    chk("sat_mc", mispredict_count, 3);

    // Random traffic, restarting from reset so counters are exercised again
    reset = 1'b1; #1; model_reset(); @(posedge clk); #1; reset = 1'b0;
    for (int i = 0; i < 400; i++)
      cyc(($urandom_range(0, 9) < 6), $urandom_range(0, 1), $urandom,
          ($urandom_range(0, 9) < 4), ($urandom_range(0, 3) != 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
